fb_sdram_arbiter: RTL and testbench

- Sequences the single SDRAM request port shared by two requesters: the BMP download writer (ioctl byte stream) and the video line prefetcher.
- Parses the BMP header pixel-data offset (bytes 10..12) and drops header bytes.
- Packs pixel bytes into masked 16-bit writes.
- Fetches one display line of 32-bit pixels per request into an external line buffer, applying bottom-up row flip.
- Sits between data_io/video timing and the sdram toggle-handshake port.

---
 rtl/fb_sdram_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_fb_sdram_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sdram_arbiter.sv
// Shares one toggle-handshake SDRAM port between the BMP download writer and the
// video line prefetcher; reads win in IDLE and a line burst is never preempted.

module fb_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        init_n,
    input  logic        push,
    input  logic [23:0] wr_rel,
    input  logic [7:0]  wr_dat,
    input  logic        pop,
    output logic [23:0] rd_rel,
    output logic [7:0]  rd_dat,
    output logic        empty,
    output logic        full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [23:0]   rel_mem [DEPTH];
    logic [7:0]    dat_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign rd_rel = rel_mem[rd_ptr];
    assign rd_dat = dat_mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push) begin
            rel_mem[wr_ptr] <= wr_rel;
            dat_mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!init_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module fb_sdram_arbiter #(
    parameter int LINE_PIXELS = 640,
    parameter int FIFO_DEPTH  = 4,
    parameter int ROW_SHIFT   = 9
) (
    input  logic        clk_sys,
    input  logic        init_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [23:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_overflow,
    output logic        bmp_loaded,
    input  logic        line_req,
    input  logic [8:0]  line_num,
    input  logic [8:0]  line_max,
    output logic        lb_we,
    output logic [9:0]  lb_addr,
    output logic [23:0] lb_data,
    output logic        line_done,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [31:0] mem_q
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_WAIT  = 2'd1;
    localparam logic [1:0] RD_WAIT  = 2'd2;
    localparam logic [1:0] RD_STORE = 2'd3;
    localparam logic [9:0] X_LAST   = 10'(LINE_PIXELS - 1);

    logic [1:0]  state;
    logic        dl_active_q;
    logic        dl_fell;
    logic [23:0] data_start;
    logic        pending;
    logic [8:0]  pend_line;
    logic [8:0]  row;
    logic [9:0]  x;

    logic        dl_rise, dl_fall;
    logic        byte_ok, push, pop, start_rd;
    logic        fifo_empty, fifo_full;
    logic        ovf_set, loaded_set, mem_done;
    logic [23:0] rel;
    logic [23:0] pop_rel;
    logic [7:0]  pop_dat;
    logic [8:0]  new_row;
    logic [9:0]  x_next;

    // Pixel (row, x) to 16-bit word address; the 24-bit byte address wraps silently.
    function automatic logic [22:0] rd_addr(input logic [8:0] r, input logic [9:0] px);
        logic [23:0] pix;
        logic [23:0] byte_a;
        pix    = ({15'd0, r} << ROW_SHIFT) + {14'd0, px};
        byte_a = pix << 2;
        return byte_a[23:1];
    endfunction

    assign dl_rise  = dl_active & ~dl_active_q;
    assign dl_fall  = ~dl_active & dl_active_q;
    assign byte_ok  = dl_wr && (dl_addr >= 24'd14) && (dl_addr >= data_start);
    assign rel      = dl_addr - data_start;
    assign start_rd = (state == IDLE) && pending;
    assign pop      = (state == IDLE) && !pending && !fifo_empty;
    // A full FIFO still accepts a byte when an entry leaves in the same cycle.
    assign push     = byte_ok && (!fifo_full || pop);
    assign ovf_set  = byte_ok && fifo_full && !pop;
    assign mem_done = (mem_ack == mem_req);
    assign new_row  = line_max - 9'd1 - pend_line;
    assign x_next   = x + 10'd1;
    assign loaded_set = !dl_active && fifo_empty && (state != WR_WAIT) && (dl_fell || dl_fall);

    assign lb_we     = (state == RD_STORE);
    assign lb_addr   = x;
    assign line_done = (state == RD_STORE) && (x == X_LAST);

    fb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .init_n  (init_n),
        .push    (push),
        .wr_rel  (rel),
        .wr_dat  (dl_data),
        .pop     (pop),
        .rd_rel  (pop_rel),
        .rd_dat  (pop_dat),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Download bookkeeping: header offset, overflow and completion flags.
    always_ff @(posedge clk_sys) begin
        if (!init_n) begin
            dl_active_q <= 1'b0;
            dl_fell     <= 1'b0;
            data_start  <= '0;
            dl_overflow <= 1'b0;
            bmp_loaded  <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (dl_rise) begin
                data_start  <= '0;
                dl_overflow <= 1'b0;
                bmp_loaded  <= 1'b0;
                dl_fell     <= 1'b0;
            end else if (dl_fall) begin
                dl_fell <= 1'b1;
            end
            if (dl_wr && dl_addr == 24'd10) data_start[7:0]   <= dl_data;
            if (dl_wr && dl_addr == 24'd11) data_start[15:8]  <= dl_data;
            if (dl_wr && dl_addr == 24'd12) data_start[23:16] <= dl_data;
            if (ovf_set)    dl_overflow <= 1'b1;
            if (loaded_set) bmp_loaded  <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!init_n) begin
            pending   <= 1'b0;
            pend_line <= '0;
        end else begin
            if (start_rd) pending <= 1'b0;
            // A request landing on the service cycle stays pending for the next burst.
            if (line_req) begin
                pending   <= 1'b1;
                pend_line <= line_num;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!init_n) begin
            state    <= IDLE;
            row      <= '0;
            x        <= '0;
            lb_data  <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_ds   <= '0;
            mem_d    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rd) begin
                        row      <= new_row;
                        x        <= '0;
                        mem_addr <= rd_addr(new_row, 10'd0);
                        mem_we   <= 1'b0;
                        mem_ds   <= 2'b11;
                        mem_d    <= '0;
                        mem_req  <= ~mem_req;
                        state    <= RD_WAIT;
                    end else if (pop) begin
                        mem_addr <= pop_rel[23:1];
                        mem_we   <= 1'b1;
                        mem_ds   <= {pop_rel[0], ~pop_rel[0]};
                        mem_d    <= {pop_dat, pop_dat};
                        mem_req  <= ~mem_req;
                        state    <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (mem_done) state <= IDLE;
                end
                RD_WAIT: begin
                    // Capture here so the store does not rely on mem_q being held.
                    if (mem_done) begin
                        lb_data <= mem_q[23:0];
                        state   <= RD_STORE;
                    end
                end
                RD_STORE: begin
                    if (x == X_LAST) begin
                        state <= IDLE;
                    end else begin
                        x        <= x_next;
                        mem_addr <= rd_addr(row, x_next);
                        mem_we   <= 1'b0;
                        mem_ds   <= 2'b11;
                        mem_d    <= '0;
                        mem_req  <= ~mem_req;
                        state    <= RD_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Scoreboarded bench: expected SDRAM transactions and line-buffer writes are queued
// as stimulus is driven; a 3-cycle toggle responder and monitors pop and compare.

module tb_fb_sdram_arbiter;
    localparam int LP = 640;

    logic        clk_sys = 1'b0;
    logic        init_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [23:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_overflow, bmp_loaded;
    logic        line_req = 1'b0;
    logic [8:0]  line_num = '0;
    logic [8:0]  line_max = 9'd312;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [23:0] lb_data;
    logic        line_done;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic [31:0] mem_q = '0;

    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [1:0]  ds;
        logic [15:0] d;
    } txn_t;
    typedef struct packed {
        logic [9:0]  a;
        logic [23:0] d;
    } lbw_t;

    txn_t exp_txn[$];
    lbw_t exp_lb[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    logic stall = 1'b0;
    logic prev_req = 1'b0;
    logic waiting = 1'b0;
    int lat = 0;
    logic [22:0] cur_addr = '0;
    txn_t e_t;
    lbw_t e_l;

    always #5 clk_sys = ~clk_sys;

    fb_sdram_arbiter dut (
        .clk_sys(clk_sys), .init_n(init_n), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_overflow(dl_overflow), .bmp_loaded(bmp_loaded),
        .line_req(line_req), .line_num(line_num), .line_max(line_max), .lb_we(lb_we),
        .lb_addr(lb_addr), .lb_data(lb_data), .line_done(line_done), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ds(mem_ds),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    // SDRAM model: checks each new request against the scoreboard, acks 3 cycles later.
    always @(negedge clk_sys) begin
        if (!init_n) begin
            mem_ack = 1'b0;
            prev_req = 1'b0;
            waiting = 1'b0;
            lat = 0;
        end else if (mem_req != prev_req) begin
            prev_req = mem_req;
            cur_addr = mem_addr;
            waiting = 1'b1;
            lat = 3;
            total++;
            if (exp_txn.size() == 0) begin
                bad++;
                $display("FAIL txn_unexpected: got we=%0d addr=%h ds=%b d=%h, required none", mem_we, mem_addr, mem_ds, mem_d);
            end else begin
                e_t = exp_txn.pop_front();
                if (mem_we !== e_t.we || mem_addr !== e_t.addr ||
                    (e_t.we && (mem_ds !== e_t.ds || mem_d !== e_t.d))) begin
                    bad++;
                    $display("FAIL txn: got we=%0d addr=%h ds=%b d=%h, required we=%0d addr=%h ds=%b d=%h",
                             mem_we, mem_addr, mem_ds, mem_d, e_t.we, e_t.addr, e_t.ds, e_t.d);
                end
            end
        end else if (waiting && !stall) begin
            if (lat > 1) lat--;
            else begin
                mem_q = {8'h5A, 1'b0, cur_addr};
                mem_ack = prev_req;
                waiting = 1'b0;
                ack_cnt++;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (lb_we === 1'b1) begin
            total++;
            if (exp_lb.size() == 0) begin
                bad++;
                $display("FAIL lb_unexpected: got addr=%0d data=%h, required none", lb_addr, lb_data);
            end else begin
                e_l = exp_lb.pop_front();
                if (lb_addr !== e_l.a || lb_data !== e_l.d) begin
                    bad++;
                    $display("FAIL lb_write: got addr=%0d data=%h, required addr=%0d data=%h", lb_addr, lb_data, e_l.a, e_l.d);
                end
            end
        end
        if (line_done === 1'b1) begin
            done_cnt++;
            total++;
            if (!(lb_we === 1'b1 && lb_addr === 10'(LP - 1))) begin
                bad++;
                $display("FAIL line_done_align: got lb_we=%b lb_addr=%0d, required 1 and %0d", lb_we, lb_addr, LP - 1);
            end
        end
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input int a, input logic [7:0] b);
        dl_wr = 1'b1;
        dl_addr = 24'(a);
        dl_data = b;
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic push_wr(input int r, input logic [7:0] b);
        txn_t t;
        t.we = 1'b1;
        t.addr = 23'(r / 2);
        t.ds = (r % 2 == 1) ? 2'b10 : 2'b01;
        t.d = {b, b};
        exp_txn.push_back(t);
    endtask

    task automatic push_line(input int line, input int lmax);
        txn_t t;
        lbw_t l;
        int row;
        row = lmax - 1 - line;
        for (int x = 0; x < LP; x++) begin
            t.we = 1'b0;
            t.addr = 23'(row * 1024 + 2 * x);
            t.ds = 2'b11;
            t.d = '0;
            exp_txn.push_back(t);
            l.a = 10'(x);
            l.d = {1'b0, t.addr};
            exp_lb.push_back(l);
        end
    endtask

    task automatic pulse_line(input int line, input int lmax);
        line_num = 9'(line);
        line_max = 9'(lmax);
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt >= target) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_txn.size() == 0 && !waiting) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset;
        init_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({mem_req, mem_we, mem_addr, mem_ds, mem_d} !== '0) begin
            bad++;
            $display("FAIL reset_mem: got req=%b we=%b addr=%h ds=%b d=%h, required all 0", mem_req, mem_we, mem_addr, mem_ds, mem_d);
        end
        total++;
        if ({lb_we, lb_addr, lb_data, line_done} !== '0) begin
            bad++;
            $display("FAIL reset_lb: got we=%b addr=%h data=%h done=%b, required all 0", lb_we, lb_addr, lb_data, line_done);
        end
        total++;
        if ({dl_overflow, bmp_loaded} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: got ovf=%b loaded=%b, required 0 0", dl_overflow, bmp_loaded);
        end
        init_n = 1'b1;
        tick();
    endtask

    task automatic test_header;
        bit ok;
        logic [7:0] b;
        for (int a = 16'h36; a <= 16'h3B; a++) push_wr(a - 16'h36, 8'(a) ^ 8'hC3);
        dl_active = 1'b1;
        tick();
        for (int a = 0; a <= 16'h3B; a++) begin
            b = 8'(a) ^ 8'hC3;
            if (a == 10) b = 8'h36;
            if (a == 11 || a == 12) b = 8'h00;
            send_byte(a, b);
            repeat (7) tick();
        end
        dl_active = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bmp_loaded === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL header_loaded: got bmp_loaded=%b, required 1", bmp_loaded); end
        total++;
        if (exp_txn.size() != 0) begin bad++; $display("FAIL header_writes: got %0d missing, required 0", exp_txn.size()); end
        total++;
        if (dl_overflow !== 1'b0) begin bad++; $display("FAIL header_ovf: got %b, required 0", dl_overflow); end
    endtask

    task automatic test_line_fetch;
        bit ok;
        int base;
        base = done_cnt;
        push_line(0, 312);
        pulse_line(0, 312);
        wait_done(base + 1, LP * 10, ok);
        repeat (20) tick();
        total++;
        if (!ok || done_cnt != base + 1) begin bad++; $display("FAIL line_fetch_done: got %0d pulses, required 1", done_cnt - base); end
        total++;
        if (exp_txn.size() != 0 || exp_lb.size() != 0) begin
            bad++;
            $display("FAIL line_fetch_count: got %0d txn %0d lb outstanding, required 0 0", exp_txn.size(), exp_lb.size());
        end
    endtask

    task automatic test_contention;
        bit ok;
        int base;
        base = done_cnt;
        push_wr(100, 8'h11);
        push_line(100, 262);
        push_wr(101, 8'h22);
        push_wr(102, 8'h33);
        dl_active = 1'b1;
        tick();
        send_byte(100, 8'h11);
        send_byte(101, 8'h22);
        send_byte(102, 8'h33);
        pulse_line(100, 262);
        wait_done(base + 1, LP * 10, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL contention_done: got %0d pulses, required 1", done_cnt - base); end
        wait_drain(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL contention_drain: got %0d outstanding, required 0", exp_txn.size()); end
        dl_active = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_overflow;
        bit ok;
        stall = 1'b1;
        for (int r = 200; r < 205; r++) push_wr(r, 8'(r));
        dl_active = 1'b1;
        tick();
        for (int r = 200; r < 206; r++) send_byte(r, 8'(r));
        tick();
        total++;
        if (dl_overflow !== 1'b1) begin bad++; $display("FAIL overflow_set: got %b, required 1", dl_overflow); end
        stall = 1'b0;
        wait_drain(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL overflow_writes: got %0d outstanding, required 0", exp_txn.size()); end
        total++;
        if (dl_overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %b, required 1", dl_overflow); end
        dl_active = 1'b0;
        repeat (2) tick();
        dl_active = 1'b1;
        tick();
        total++;
        if (dl_overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %b, required 0", dl_overflow); end
        dl_active = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_two_reqs;
        bit ok;
        int base;
        base = done_cnt;
        push_line(3, 262);
        push_line(7, 262);
        pulse_line(3, 262);
        repeat (40) tick();
        pulse_line(5, 262);
        repeat (40) tick();
        pulse_line(7, 262);
        wait_done(base + 2, LP * 20, ok);
        repeat (40) tick();
        total++;
        if (!ok || done_cnt != base + 2) begin bad++; $display("FAIL two_reqs_bursts: got %0d, required 2", done_cnt - base); end
        total++;
        if (exp_txn.size() != 0 || exp_lb.size() != 0) begin
            bad++;
            $display("FAIL two_reqs_order: got %0d txn %0d lb outstanding, required 0 0", exp_txn.size(), exp_lb.size());
        end
    endtask

    task automatic test_completion;
        bit early;
        bit ok;
        int base;
        dl_active = 1'b1;
        tick();
        stall = 1'b1;
        push_wr(300, 8'hA0);
        push_wr(301, 8'hA1);
        send_byte(300, 8'hA0);
        send_byte(301, 8'hA1);
        tick();
        dl_active = 1'b0;
        base = ack_cnt;
        early = 1'b0;
        repeat (10) begin
            tick();
            if (bmp_loaded !== 1'b0) early = 1'b1;
        end
        stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bmp_loaded === 1'b1) begin
                ok = 1'b1;
                if (ack_cnt < base + 2) early = 1'b1;
                break;
            end
        end
        total++;
        if (early) begin bad++; $display("FAIL loaded_early: got bmp_loaded=1 after %0d acks, required 2", ack_cnt - base); end
        total++;
        if (!ok || ack_cnt != base + 2) begin bad++; $display("FAIL loaded_rise: got loaded=%b acks=%0d, required 1 and 2", bmp_loaded, ack_cnt - base); end
    endtask

    task automatic test_reset_abort;
        bit ok;
        int base;
        txn_t t;
        base = done_cnt;
        stall = 1'b1;
        t.we = 1'b0;
        t.addr = 23'(291 * 1024);
        t.ds = 2'b11;
        t.d = '0;
        exp_txn.push_back(t);
        pulse_line(20, 312);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (waiting) begin ok = 1'b1; break; end
            tick();
        end
        total++;
        if (!ok) begin bad++; $display("FAIL abort_issue: got no read issued, required one"); end
        init_n = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        total++;
        if ({mem_req, mem_we, mem_addr, mem_ds, mem_d, lb_we, lb_addr, lb_data, line_done, dl_overflow, bmp_loaded} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: got req=%b addr=%h lb_we=%b lb_addr=%0d done=%b loaded=%b, required all 0",
                     mem_req, mem_addr, lb_we, lb_addr, line_done, bmp_loaded);
        end
        tick();
        init_n = 1'b1;
        stall = 1'b0;
        repeat (30) tick();
        total++;
        if (done_cnt != base || exp_txn.size() != 0 || exp_lb.size() != 0) begin
            bad++;
            $display("FAIL abort_quiet: got done=%0d txn=%0d lb=%0d, required 0 0 0", done_cnt - base, exp_txn.size(), exp_lb.size());
        end
    endtask

    initial begin
        test_reset();
        test_header();
        test_line_fetch();
        test_contention();
        test_overflow();
        test_two_reqs();
        test_completion();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
